ecc_ram_scrubber: RTL

- Background scrubber for the 32-bit soft-ECC RAM. Owns port B of the ECC RAM exclusively and walks every word address in turn.
- For each word it reads the word, then samples the decoder's corrected data and 3-bit error status.
- Words flagged "corrected" are written back so single-bit upsets do not accumulate into uncorrectable double-bit errors.
- Keeps saturating statistics and captures the first uncorrectable address for software.

---
 rtl/ecc_ram_scrubber.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ecc_ram_scrubber.sv
// Background scrubber for the soft-ECC RAM port B: reads each word, writes back
// corrected words and keeps saturating statistics plus the first fatal address.
module ecc_ram_scrubber #(
    parameter int  NUM_WORDS      = 512,
    parameter int  READ_LATENCY   = 4,
    parameter int  INTERVAL_WIDTH = 16,
    parameter int  CNT_WIDTH      = 16,
    localparam int ADDR_WIDTH     = (NUM_WORDS > 2) ? $clog2(NUM_WORDS - 1) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [INTERVAL_WIDTH-1:0] interval,
    input  logic                      clear_stats,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [31:0]               ram_data,
    output logic                      ram_wren,
    input  logic [31:0]               ram_q,
    input  logic [2:0]                ram_err,
    output logic                      busy,
    output logic                      pass_done,
    output logic [CNT_WIDTH-1:0]      corr_count,
    output logic [CNT_WIDTH-1:0]      fatal_count,
    output logic                      fatal_seen,
    output logic [ADDR_WIDTH-1:0]     fatal_addr
);

    // state | meaning
    // IDLE  | parked, pointer preserved
    // READ  | issue read address
    // WAIT  | RAM read latency
    // CHECK | sample decoded data and error status
    // WRITE | two-cycle write-back of corrected word
    // NEXT  | advance pointer, load idle interval
    // GAP   | idle between words; only exit point to IDLE
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_GAP   = 3'd6;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [3:0]            LAT_LOAD  = 4'(READ_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    logic [2:0]                state_q, state_d;
    logic [ADDR_WIDTH-1:0]     ptr_q, ptr_d;
    logic [3:0]                lat_cnt_q, lat_cnt_d;
    logic [INTERVAL_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic                      wr_second_q, wr_second_d;
    logic [ADDR_WIDTH-1:0]     ram_addr_q, ram_addr_d;
    logic [31:0]               ram_data_q, ram_data_d;
    logic                      ram_wren_q, ram_wren_d;
    logic                      busy_q, busy_d;
    logic                      pass_done_q, pass_done_d;
    logic [CNT_WIDTH-1:0]      corr_count_q, corr_count_d;
    logic [CNT_WIDTH-1:0]      fatal_count_q, fatal_count_d;
    logic                      fatal_seen_q, fatal_seen_d;
    logic [ADDR_WIDTH-1:0]     fatal_addr_q, fatal_addr_d;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        lat_cnt_d     = lat_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        wr_second_d   = wr_second_q;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = ram_wren_q;
        pass_done_d   = 1'b0;
        corr_count_d  = corr_count_q;
        fatal_count_d = fatal_count_q;
        fatal_seen_d  = fatal_seen_q;
        fatal_addr_d  = fatal_addr_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_READ;
                    ram_addr_d = ptr_q;
                end
            end
            S_READ: begin
                lat_cnt_d = LAT_LOAD;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                casez (ram_err)
                    3'b1??: begin
                        if (fatal_count_q != CNT_MAX) begin
                            fatal_count_d = fatal_count_q + CNT_WIDTH'(1);
                        end
                        if (!fatal_seen_q) begin
                            fatal_seen_d = 1'b1;
                            fatal_addr_d = ptr_q;
                        end
                        state_d = S_NEXT;
                    end
                    3'b01?: begin
                        ram_data_d  = ram_q;
                        ram_wren_d  = 1'b1;
                        wr_second_d = 1'b0;
                        state_d     = S_WRITE;
                    end
                    default: state_d = S_NEXT;
                endcase
            end
            S_WRITE: begin
                if (!wr_second_q) begin
                    wr_second_d = 1'b1;
                    if (corr_count_q != CNT_MAX) begin
                        corr_count_d = corr_count_q + CNT_WIDTH'(1);
                    end
                end else begin
                    ram_wren_d = 1'b0;
                    state_d    = S_NEXT;
                end
            end
            S_NEXT: begin
                if (ptr_q == LAST_ADDR) begin
                    ptr_d       = '0;
                    pass_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_WIDTH'(1);
                end
                gap_cnt_d = interval;
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (enable) begin
                        state_d    = S_READ;
                        ram_addr_d = ptr_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - INTERVAL_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear overrides any increment or capture made this cycle.
        if (clear_stats) begin
            corr_count_d  = '0;
            fatal_count_d = '0;
            fatal_seen_d  = 1'b0;
            fatal_addr_d  = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            lat_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            wr_second_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            busy_q        <= 1'b0;
            pass_done_q   <= 1'b0;
            corr_count_q  <= '0;
            fatal_count_q <= '0;
            fatal_seen_q  <= 1'b0;
            fatal_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            lat_cnt_q     <= lat_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            wr_second_q   <= wr_second_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            busy_q        <= busy_d;
            pass_done_q   <= pass_done_d;
            corr_count_q  <= corr_count_d;
            fatal_count_q <= fatal_count_d;
            fatal_seen_q  <= fatal_seen_d;
            fatal_addr_q  <= fatal_addr_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = busy_q;
    assign pass_done   = pass_done_q;
    assign corr_count  = corr_count_q;
    assign fatal_count = fatal_count_q;
    assign fatal_seen  = fatal_seen_q;
    assign fatal_addr  = fatal_addr_q;

endmodule
